// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and types for the DDS phase/address datapath.
//   DDS_ACC_W / DDS_AW / DDS_PRESC_W : default accumulator, LUT address and prescaler widths
//   quad_e                           : quadrant encoding of the two phase MSBs
//   tw_t                             : tuning-word type at the default accumulator width
package dds_pkg;

   localparam int unsigned DDS_ACC_W   = 16;
   localparam int unsigned DDS_AW      = 4;
   localparam int unsigned DDS_PRESC_W = 8;

   // Quadrant of the waveform, taken from the two phase MSBs.
   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_e;

   typedef logic [DDS_ACC_W-1:0] tw_t;

endpackage : dds_pkg

// File: rtl/dds_quarter_map.sv
// dds_quarter_map: combinational phase -> LUT address / sign mapping.
//   phase_msb : top AW+2 bits of the phase (the only bits the mapping depends on)
//   quarter   : 1 = quarter-wave mirroring, 0 = direct full-wave addressing
//   lut_ra_c  : LUT address
//   sign_c    : 1 = negative waveform half (quarter mode only)
module dds_quarter_map
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W = DDS_ACC_W,
   parameter int unsigned AW    = DDS_AW
) (
   input  logic [AW+1:0] phase_msb,
   input  logic          quarter,
   output logic [AW-1:0] lut_ra_c,
   output logic          sign_c
);

   if (ACC_W < AW + 2) begin : g_bad_width
      $error("dds_quarter_map: ACC_W must be at least AW+2");
   end

   quad_e         quad;
   logic [AW-1:0] frac;

   // Full-wave: top AW bits. Quarter-wave: mirror odd quadrants, sign from upper half.
   always_comb begin
      quad     = quad_e'(phase_msb[AW+1:AW]);
      frac     = phase_msb[AW-1:0];
      lut_ra_c = phase_msb[AW+1 -: AW];
      sign_c   = 1'b0;
      if (quarter) begin
         case (quad)
            Q1, Q3:  lut_ra_c = ~frac;
            default: lut_ra_c = frac;
         endcase
         sign_c = (quad == Q2) || (quad == Q3);
      end
   end

endmodule : dds_quarter_map

// File: rtl/dds_phase_accum.sv
// dds_phase_accum: prescaled phase accumulator driving the waveform LUT read port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ena             : run enable; low freezes counting and suppresses strobes
//   tw_wr/tw_sel/tw_byte : byte write into the shadow tuning word
//   commit          : request to move the shadow word to the active word on a later tick
//   presc           : phase advances once per presc+1 enabled cycles
//   quarter         : quarter-wave mirroring mode
//   lut_re/lut_ra   : LUT read strobe and address (registered)
//   sign            : negative waveform half (registered)
//   wrap            : phase carried out of the accumulator on this step (registered)
//   pending         : a commit is waiting for the next tick
module dds_phase_accum
   import dds_pkg::*;
#(
   parameter int unsigned ACC_W   = DDS_ACC_W,
   parameter int unsigned AW      = DDS_AW,
   parameter int unsigned PRESC_W = DDS_PRESC_W,
   parameter int unsigned SEL_W   = ((ACC_W / 8) > 1) ? $clog2(ACC_W / 8) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               tw_wr,
   input  logic [SEL_W-1:0]   tw_sel,
   input  logic [7:0]         tw_byte,
   input  logic               commit,
   input  logic [PRESC_W-1:0] presc,
   input  logic               quarter,
   output logic               lut_re,
   output logic [AW-1:0]      lut_ra,
   output logic               sign,
   output logic               wrap,
   output logic               pending
);

   localparam int unsigned NBYTES = ACC_W / 8;

   logic [PRESC_W-1:0] cnt_q,     cnt_d;
   logic [ACC_W-1:0]   shadow_q,  shadow_d;
   logic [ACC_W-1:0]   tw_act_q,  tw_act_d;
   logic [ACC_W-1:0]   phase_q,   phase_d;
   logic               pending_q, pending_d;
   logic               lut_re_q,  lut_re_d;
   logic [AW-1:0]      lut_ra_q,  lut_ra_d;
   logic               sign_q,    sign_d;
   logic               wrap_q,    wrap_d;

   logic               tick_c;
   logic [ACC_W-1:0]   step_c;
   logic [ACC_W:0]     sum_c;
   logic [AW-1:0]      map_ra_c;
   logic               map_sign_c;

   // Prescaler: >= lets a reduced presc tick immediately instead of wrapping the counter.
   always_comb begin
      tick_c = ena && (cnt_q >= presc);
      cnt_d  = cnt_q;
      if (tick_c) begin
         cnt_d = '0;
      end else if (ena) begin
         cnt_d = cnt_q + PRESC_W'(1);
      end
   end

   // Shadow word byte writes; indices beyond the word match no byte and are dropped.
   always_comb begin
      shadow_d = shadow_q;
      if (tw_wr) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (tw_sel == SEL_W'(i)) begin
               shadow_d[i*8 +: 8] = tw_byte;
            end
         end
      end
   end

   // A pending commit is consumed by the next tick and that step already uses the new word.
   // pending_q is still 0 on a tick coincident with commit, which defers it one tick.
   always_comb begin
      step_c    = pending_q ? shadow_q : tw_act_q;
      sum_c     = {1'b0, phase_q} + {1'b0, step_c};
      tw_act_d  = tw_act_q;
      phase_d   = phase_q;
      pending_d = pending_q;
      if (tick_c) begin
         phase_d = sum_c[ACC_W-1:0];
      end
      if (tick_c && pending_q) begin
         tw_act_d  = shadow_q;
         pending_d = 1'b0;
      end else if (commit) begin
         pending_d = 1'b1;
      end
   end

   dds_quarter_map #(
      .ACC_W (ACC_W),
      .AW    (AW)
   ) u_map (
      .phase_msb (sum_c[ACC_W-1 -: AW+2]),
      .quarter   (quarter),
      .lut_ra_c  (map_ra_c),
      .sign_c    (map_sign_c)
   );

   // Output stage: strobes follow the tick, address and sign hold between ticks.
   always_comb begin
      lut_re_d = tick_c;
      wrap_d   = tick_c && sum_c[ACC_W];
      lut_ra_d = lut_ra_q;
      sign_d   = sign_q;
      if (tick_c) begin
         lut_ra_d = map_ra_c;
         sign_d   = map_sign_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         shadow_q  <= '0;
         tw_act_q  <= '0;
         phase_q   <= '0;
         pending_q <= 1'b0;
         lut_re_q  <= 1'b0;
         lut_ra_q  <= '0;
         sign_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         tw_act_q  <= tw_act_d;
         phase_q   <= phase_d;
         pending_q <= pending_d;
         lut_re_q  <= lut_re_d;
         lut_ra_q  <= lut_ra_d;
         sign_q    <= sign_d;
         wrap_q    <= wrap_d;
      end
   end

   assign lut_re  = lut_re_q;
   assign lut_ra  = lut_ra_q;
   assign sign    = sign_q;
   assign wrap    = wrap_q;
   assign pending = pending_q;

endmodule : dds_phase_accum

// File: tb/tb_dds_phase_accum.sv
// tb_dds_phase_accum: directed scoreboard bench for dds_phase_accum.
module tb_dds_phase_accum;
   import dds_pkg::*;

   localparam int unsigned ACC_W   = 16;
   localparam int unsigned AW      = 4;
   localparam int unsigned PRESC_W = 8;
   localparam int unsigned SEL_W   = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ena;
   logic               tw_wr;
   logic [SEL_W-1:0]   tw_sel;
   logic [7:0]         tw_byte;
   logic               commit;
   logic [PRESC_W-1:0] presc;
   logic               quarter;
   logic               lut_re;
   logic [AW-1:0]      lut_ra;
   logic               sign;
   logic               wrap;
   logic               pending;

   always #5 clk = ~clk;

   dds_phase_accum #(
      .ACC_W   (ACC_W),
      .AW      (AW),
      .PRESC_W (PRESC_W),
      .SEL_W   (SEL_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .tw_wr   (tw_wr),
      .tw_sel  (tw_sel),
      .tw_byte (tw_byte),
      .commit  (commit),
      .presc   (presc),
      .quarter (quarter),
      .lut_re  (lut_re),
      .lut_ra  (lut_ra),
      .sign    (sign),
      .wrap    (wrap),
      .pending (pending)
   );

   // Expected LUT read: address, sign, wrap and cycles since previous pulse (0 = unchecked).
   typedef struct {
      logic [AW-1:0] ra;
      logic          sign;
      logic          wrap;
      int            gap;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   cyc        = 0;
   int   last_pulse = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input int ra, input bit sg, input bit wr, input int gap);
      exp_t e;
      e.ra   = AW'(ra);
      e.sign = sg;
      e.wrap = wr;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // Run n cycles, matching each lut_re pulse against the scoreboard head.
   task automatic drain(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (lut_re === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", 32'(lut_re), 32'd0);
            end else begin
               e = sb.pop_front();
               check("lut_ra", 32'(lut_ra), 32'(e.ra));
               check("sign",   32'(sign),   32'(e.sign));
               check("wrap",   32'(wrap),   32'(e.wrap));
               if (e.gap != 0) check("pulse_gap", 32'(cyc - last_pulse), 32'(e.gap));
            end
            last_pulse = cyc;
         end else begin
            check("wrap_idle", 32'(wrap), 32'd0);
         end
      end
      check("missing_pulses", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic write_byte(input int sel, input logic [7:0] b);
      tw_wr   = 1'b1;
      tw_sel  = SEL_W'(sel);
      tw_byte = b;
      @(negedge clk);
      tw_wr   = 1'b0;
   endtask

   task automatic commit_req();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
      check("pending_rise", 32'(pending), 32'd1);
   endtask

   // Asynchronous reset between clock edges; outputs must clear before any edge.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_lut_re",  32'(lut_re),  32'd0);
      check("rst_lut_ra",  32'(lut_ra),  32'd0);
      check("rst_sign",    32'(sign),    32'd0);
      check("rst_wrap",    32'(wrap),    32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int qd;
      int fr;
      rst_n   = 1'b0;
      ena     = 1'b0;
      tw_wr   = 1'b0;
      tw_sel  = '0;
      tw_byte = '0;
      commit  = 1'b0;
      presc   = '0;
      quarter = 1'b0;

      repeat (3) @(negedge clk);
      check("init_lut_re",  32'(lut_re),  32'd0);
      check("init_lut_ra",  32'(lut_ra),  32'd0);
      check("init_sign",    32'(sign),    32'd0);
      check("init_wrap",    32'(wrap),    32'd0);
      check("init_pending", 32'(pending), 32'd0);
      rst_n = 1'b1;

      // Word 0x1000, presc 0: address counts 1..15,0 with wrap on the 0.
      write_byte(0, 8'h00);
      write_byte(1, 8'h10);
      commit_req();
      ena = 1'b1;
      sb_push(1, 0, 0, 0);
      drain(1);
      check("pending_fall", 32'(pending), 32'd0);
      for (int k = 2; k <= 16; k++) sb_push(k % 16, 0, k == 16, 1);
      drain(15);

      // Mid-run asynchronous reset, then a zero word keeps the address at 0.
      for (int k = 1; k <= 3; k++) sb_push(k, 0, 0, (k == 1) ? 0 : 1);
      drain(3);
      async_reset();
      for (int k = 0; k < 4; k++) sb_push(0, 0, 0, (k == 0) ? 0 : 1);
      drain(4);
      check("pending_after_rst", 32'(pending), 32'd0);
      ena = 1'b0;

      // presc 3: one pulse every 4 cycles; 5-cycle ena drop pauses without breaking the sequence.
      presc = 8'd3;
      write_byte(0, 8'h00);
      write_byte(1, 8'h10);
      commit_req();
      ena = 1'b1;
      sb_push(1, 0, 0, 0);
      drain(4);
      for (int k = 2; k <= 4; k++) sb_push(k, 0, 0, 4);
      drain(12);
      ena = 1'b0;
      drain(5);
      check("hold_lut_ra", 32'(lut_ra), 32'd4);
      ena = 1'b1;
      sb_push(5, 0, 0, 9);
      for (int k = 6; k <= 8; k++) sb_push(k, 0, 0, 4);
      drain(16);
      ena = 1'b0;

      // Quarter-wave with word 0x0400: up, mirrored down, then negative half.
      quarter = 1'b1;
      presc   = 8'd0;
      async_reset();
      write_byte(0, 8'h00);
      write_byte(1, 8'h04);
      commit_req();
      ena = 1'b1;
      for (int k = 1; k <= 64; k++) begin
         qd = (k / 16) % 4;
         fr = k % 16;
         sb_push(((qd % 2) == 1) ? (15 - fr) : fr, qd >= 2, k == 64, (k == 1) ? 0 : 1);
      end
      drain(64);
      ena = 1'b0;

      // Commit coincident with a tick (presc 2) is deferred one tick; a write while pending is applied.
      quarter = 1'b0;
      presc   = 8'd2;
      write_byte(1, 8'h20);
      ena = 1'b1;
      drain(2);
      commit = 1'b1;
      sb_push(0, 0, 0, 0);
      drain(1);
      commit = 1'b0;
      check("pending_held", 32'(pending), 32'd1);
      drain(1);
      tw_wr   = 1'b1;
      tw_sel  = SEL_W'(1);
      tw_byte = 8'h30;
      drain(1);
      tw_wr = 1'b0;
      sb_push(3, 0, 0, 3);
      drain(1);
      check("pending_cleared", 32'(pending), 32'd0);
      sb_push(6, 0, 0, 3);
      sb_push(9, 0, 0, 3);
      drain(6);
      ena = 1'b0;

      // presc 200 reduced to 1 at cnt 50: tick on the next enabled cycle, then every 2.
      presc = 8'd200;
      ena   = 1'b1;
      drain(50);
      presc = 8'd1;
      sb_push(12, 0, 0, 0);
      drain(1);
      sb_push(15, 0, 0, 2);
      sb_push(2, 0, 1, 2);
      sb_push(5, 0, 0, 2);
      drain(6);
      ena = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_dds_phase_accum
